// File: rtl/conv_slot_scheduler.sv
// -----------------------------------------------------------------------------
// conv_slot_scheduler
//
// Shares the converter mux fabric between the ADC capture path and the two DAC
// update paths. One requester is granted at a time in round-robin order. Its
// 19-bit mux pattern is held for a settle period before the matching converter
// control line asserts. A bounded active window follows, then a guard gap with
// the mux parked at zero. Everything runs in the 10 MHz domain.
//
// Parameters
//   SETTLE_CYCLES  cycles the mux pattern is held before control asserts (1..255)
//   SLOT_CYCLES    maximum active-window length                            (1..255)
//   GUARD_CYCLES   parked gap after each slot                              (1..255)
//
// Ports
//   clk_10MHz      sole clock, rising edge
//   reset          synchronous, active-high
//   locked         clock-source lock; no grants while low, aborts a running slot
//   req[2:0]       level requests: bit0 adc, bit1 dac1, bit2 dac2
//   done[2:0]      early slot end; only the granted bit is honoured
//   mux_cfg_*      per-requester mux pattern, captured at grant
//   grant[2:0]     one-hot grant or zero
//   *_control      converter enable, high only while the slot is active
//   mux_signals    registered mux pattern of the granted requester
//   busy           high whenever the scheduler is not idle
//   slot_overrun   one-cycle pulse when a slot ends on timeout
// -----------------------------------------------------------------------------
module conv_slot_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SLOT_CYCLES   = 16,
    parameter int unsigned GUARD_CYCLES  = 2
) (
    input  logic        clk_10MHz,
    input  logic        reset,
    input  logic        locked,
    input  logic [2:0]  req,
    input  logic [2:0]  done,
    input  logic [18:0] mux_cfg_adc,
    input  logic [18:0] mux_cfg_dac1,
    input  logic [18:0] mux_cfg_dac2,
    output logic [2:0]  grant,
    output logic        adc_control,
    output logic        dac1_control,
    output logic        dac2_control,
    output logic [18:0] mux_signals,
    output logic        busy,
    output logic        slot_overrun
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned REQ_W = 3;
    localparam int unsigned MUX_W = 19;
    localparam int unsigned IDX_W = 2;

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);

    // Requester indices; the pointer holds the index of the last winner.
    localparam logic [IDX_W-1:0] IDX_ADC  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_DAC1 = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_DAC2 = IDX_W'(2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        GUARD  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   last_d;

    logic [REQ_W-1:0]   grant_d;
    logic [MUX_W-1:0]   mux_d;
    logic [REQ_W-1:0]   ctrl_d;
    logic [REQ_W-1:0]   ctrl_q;
    logic               busy_d;
    logic               overrun_d;

    logic [IDX_W-1:0]   win_idx_c;
    logic               win_valid_c;
    logic [REQ_W-1:0]   win_onehot_c;
    logic [MUX_W-1:0]   win_cfg_c;
    logic               slot_done_c;

    // Round-robin pick: first requesting bit after the last winner, cyclically.
    always_comb begin
        win_valid_c = |req;
        win_idx_c   = last_q;
        unique case (last_q)
            IDX_ADC:  win_idx_c = req[1] ? IDX_DAC1 : (req[2] ? IDX_DAC2 : IDX_ADC);
            IDX_DAC1: win_idx_c = req[2] ? IDX_DAC2 : (req[0] ? IDX_ADC  : IDX_DAC1);
            default:  win_idx_c = req[0] ? IDX_ADC  : (req[1] ? IDX_DAC1 : IDX_DAC2);
        endcase
    end

    // Winner's one-hot grant and mux pattern.
    always_comb begin
        win_onehot_c = REQ_W'(3'b001 << win_idx_c);
        unique case (win_idx_c)
            IDX_ADC:  win_cfg_c = mux_cfg_adc;
            IDX_DAC1: win_cfg_c = mux_cfg_dac1;
            default:  win_cfg_c = mux_cfg_dac2;
        endcase
    end

    // Only the done bit of the current grant can end the window early.
    assign slot_done_c = |(done & grant);

    // State and registered-output update.
    always_ff @(posedge clk_10MHz) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= IDX_DAC2;
            grant        <= '0;
            mux_signals  <= '0;
            ctrl_q       <= '0;
            busy         <= 1'b0;
            slot_overrun <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            grant        <= grant_d;
            mux_signals  <= mux_d;
            ctrl_q       <= ctrl_d;
            busy         <= busy_d;
            slot_overrun <= overrun_d;
        end
    end

    // Next state plus the values every output takes after the coming edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_d   = grant;
        mux_d     = mux_signals;
        overrun_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                mux_d   = '0;
                cnt_d   = '0;
                if (locked && win_valid_c) begin
                    state_d = SETUP;
                    grant_d = win_onehot_c;
                    mux_d   = win_cfg_c;
                    last_d  = win_idx_c;
                end
            end

            SETUP: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ACTIVE: begin
                // done on the final cycle wins over timeout: no overrun then.
                if (slot_done_c || (cnt_q == SLOT_LAST)) begin
                    state_d   = GUARD;
                    cnt_d     = '0;
                    grant_d   = '0;
                    mux_d     = '0;
                    overrun_d = ~slot_done_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GUARD: begin
                grant_d = '0;
                mux_d   = '0;
                if (cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                grant_d = '0;
                mux_d   = '0;
            end
        endcase

        // Lock loss aborts any slot silently; the pointer keeps the aborted winner.
        if ((state_q != IDLE) && !locked) begin
            state_d   = IDLE;
            cnt_d     = '0;
            grant_d   = '0;
            mux_d     = '0;
            overrun_d = 1'b0;
        end

        ctrl_d = (state_d == ACTIVE) ? grant_d : '0;
        busy_d = (state_d != IDLE);
    end

    assign adc_control  = ctrl_q[0];
    assign dac1_control = ctrl_q[1];
    assign dac2_control = ctrl_q[2];

endmodule

// File: tb/tb_conv_slot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_slot_scheduler
//
// Directed bench for conv_slot_scheduler. A slot-timeline model (cycles since
// grant, active length once known) predicts every output each cycle; a monitor
// logs grants, control pulse lengths and overrun pulses for hand-computed checks.
// -----------------------------------------------------------------------------
module tb_conv_slot_scheduler;

    localparam int SETTLE = 2;
    localparam int SLOT   = 16;
    localparam int GUARD  = 2;

    logic        clk_10MHz = 1'b0;
    logic        reset;
    logic        locked;
    logic [2:0]  req;
    logic [2:0]  done;
    logic [18:0] mux_cfg_adc;
    logic [18:0] mux_cfg_dac1;
    logic [18:0] mux_cfg_dac2;
    logic [2:0]  grant;
    logic        adc_control;
    logic        dac1_control;
    logic        dac2_control;
    logic [18:0] mux_signals;
    logic        busy;
    logic        slot_overrun;

    always #50 clk_10MHz = ~clk_10MHz;

    conv_slot_scheduler #(
        .SETTLE_CYCLES(SETTLE),
        .SLOT_CYCLES  (SLOT),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk_10MHz   (clk_10MHz),
        .reset       (reset),
        .locked      (locked),
        .req         (req),
        .done        (done),
        .mux_cfg_adc (mux_cfg_adc),
        .mux_cfg_dac1(mux_cfg_dac1),
        .mux_cfg_dac2(mux_cfg_dac2),
        .grant       (grant),
        .adc_control (adc_control),
        .dac1_control(dac1_control),
        .dac2_control(dac2_control),
        .mux_signals (mux_signals),
        .busy        (busy),
        .slot_overrun(slot_overrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- slot-timeline model ----------------
    // m_t counts cycles since the grant edge; setup is t<SETTLE, active lasts
    // m_len cycles once known, guard follows for GUARD cycles.
    bit          m_valid     = 1'b0;
    bit          m_in_slot   = 1'b0;
    int          m_t         = 0;
    int          m_w         = 0;
    int          m_last      = 2;
    logic [18:0] m_cfg       = '0;
    bit          m_len_known = 1'b0;
    int          m_len       = 0;
    bit          m_timeout   = 1'b0;
    int          idx;
    bit          found;

    always @(posedge clk_10MHz) begin
        m_valid = 1'b1;
        if (reset) begin
            m_in_slot = 1'b0;
            m_last    = 2;
        end else if (m_in_slot) begin
            if (!locked) begin
                m_in_slot = 1'b0;
            end else begin
                if (!m_len_known && m_t >= SETTLE) begin
                    if (done[2'(m_w)]) begin
                        m_len = m_t - SETTLE + 1;
                        m_len_known = 1'b1;
                        m_timeout = 1'b0;
                    end else if (m_t - SETTLE + 1 == SLOT) begin
                        m_len = SLOT;
                        m_len_known = 1'b1;
                        m_timeout = 1'b1;
                    end
                end
                m_t++;
                if (m_len_known && m_t == SETTLE + m_len + GUARD) m_in_slot = 1'b0;
            end
        end else if (locked && req != 3'b000) begin
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                idx = (m_last + k) % 3;
                if (!found && req[2'(idx)]) begin
                    found = 1'b1;
                    m_w = idx;
                end
            end
            m_last = m_w;
            m_in_slot = 1'b1;
            m_t = 0;
            m_len_known = 1'b0;
            m_len = 0;
            m_timeout = 1'b0;
            case (m_w)
                0:       m_cfg = mux_cfg_adc;
                1:       m_cfg = mux_cfg_dac1;
                default: m_cfg = mux_cfg_dac2;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        e_setup, e_active, e_busy, e_ovr;
    logic [2:0]  e_oh, e_grant, e_ctrl;
    logic [18:0] e_mux;

    always @(negedge clk_10MHz) begin
        if (m_valid) begin
            e_setup  = m_in_slot && (m_t < SETTLE);
            e_active = m_in_slot && (m_t >= SETTLE) && !(m_len_known && (m_t >= SETTLE + m_len));
            e_oh     = 3'(1 << m_w);
            e_grant  = (e_setup || e_active) ? e_oh : 3'b000;
            e_mux    = (e_setup || e_active) ? m_cfg : 19'h0;
            e_ctrl   = e_active ? e_oh : 3'b000;
            e_busy   = m_in_slot;
            e_ovr    = m_in_slot && m_len_known && m_timeout && (m_t == SETTLE + m_len);
            chk("cyc_grant", 32'(grant), 32'(e_grant));
            chk("cyc_mux", 32'(mux_signals), 32'(e_mux));
            chk("cyc_ctrl", 32'({dac2_control, dac1_control, adc_control}), 32'(e_ctrl));
            chk("cyc_busy", 32'(busy), 32'(e_busy));
            chk("cyc_overrun", 32'(slot_overrun), 32'(e_ovr));
        end
    end

    // ---------------- event monitor ----------------
    logic [2:0] gq[$];
    int         gcyc[$];
    int         rcyc[$];
    int         clen[$];
    int         ovr_cnt = 0;
    int         cyc     = 0;
    int         run     = 0;
    logic [2:0] prev_g  = 3'b000;
    logic       prev_c  = 1'b0;
    logic       ctrl_any;

    always @(posedge clk_10MHz) begin
        #1;
        cyc++;
        if (grant != 3'b000 && prev_g == 3'b000) begin
            gq.push_back(grant);
            gcyc.push_back(cyc);
        end
        ctrl_any = adc_control | dac1_control | dac2_control;
        if (ctrl_any) begin
            if (!prev_c) rcyc.push_back(cyc);
            run++;
        end else if (prev_c) begin
            clen.push_back(run);
            run = 0;
        end
        if (slot_overrun) ovr_cnt++;
        prev_g = grant;
        prev_c = ctrl_any;
    end

    task automatic clear_logs();
        gq.delete();
        gcyc.delete();
        rcyc.delete();
        clen.delete();
        ovr_cnt = 0;
    endtask

    // Wait until the model is in the slot at cycle tt since grant.
    task automatic wait_phase(input int tt, input int budget);
        int n = 0;
        while (!(m_in_slot && m_t == tt) && n < budget) begin
            @(negedge clk_10MHz);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_phase t=%0d: timed out after %0d cycles", tt, budget);
        end
    endtask

    task automatic wait_grants(input int cnt, input int budget);
        int n = 0;
        while (gq.size() < cnt && n < budget) begin
            @(negedge clk_10MHz);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_grants %0d: only %0d seen", cnt, gq.size());
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_in_slot && n < budget) begin
            @(negedge clk_10MHz);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: timed out after %0d cycles", budget);
        end
        @(negedge clk_10MHz);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        locked       = 1'b0;
        req          = 3'b000;
        done         = 3'b000;
        mux_cfg_adc  = 19'h12345;
        mux_cfg_dac1 = 19'h00001;
        mux_cfg_dac2 = 19'h2AAAA;
        repeat (3) @(negedge clk_10MHz);

        // Reset and single timeout slot
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset  = 1'b0;
        locked = 1'b1;
        @(negedge clk_10MHz);
        clear_logs();
        req = 3'b001;
        wait_phase(0, 10);
        chk("s1_grant", 32'(grant), 32'h1);
        chk("s1_mux", 32'(mux_signals), 32'h12345);
        wait_grants(2, 60);
        req = 3'b000;
        wait_idle(60);
        chk("s1_first_grant", 32'(gq[0]), 32'h1);
        chk("s1_second_grant", 32'(gq[1]), 32'h1);
        chk("s1_ctrl_len", 32'(clen[0]), 32'd16);
        chk("s1_settle_delay", 32'(rcyc[0] - gcyc[0]), 32'd2);
        chk("s1_slot_spacing", 32'(gcyc[1] - gcyc[0]), 32'd21);
        chk("s1_overruns", 32'(ovr_cnt), 32'd2);

        // Round robin with done on active cycle 4
        reset = 1'b1;
        @(negedge clk_10MHz);
        reset = 1'b0;
        clear_logs();
        req = 3'b111;
        for (int s = 0; s < 4; s++) begin
            wait_phase(SETTLE + 3, 40);
            done = 3'(1 << m_w);
            @(negedge clk_10MHz);
            done = 3'b000;
        end
        req = 3'b000;
        wait_idle(30);
        chk("rr_g0", 32'(gq[0]), 32'h1);
        chk("rr_g1", 32'(gq[1]), 32'h2);
        chk("rr_g2", 32'(gq[2]), 32'h4);
        chk("rr_g3", 32'(gq[3]), 32'h1);
        chk("rr_count", 32'(gq.size()), 32'd4);
        for (int s = 0; s < 4; s++) chk("rr_ctrl_len", 32'(clen[s]), 32'd4);
        chk("rr_overruns", 32'(ovr_cnt), 32'd0);

        // done held through setup only: full-length slot
        clear_logs();
        req  = 3'b010;
        done = 3'b010;
        wait_phase(SETTLE, 20);
        done = 3'b000;
        req  = 3'b000;
        wait_idle(60);
        chk("dsetup_grant", 32'(gq[0]), 32'h2);
        chk("dsetup_len", 32'(clen[0]), 32'd16);
        chk("dsetup_ovr", 32'(ovr_cnt), 32'd1);

        // done on the final active cycle: no overrun
        clear_logs();
        req = 3'b100;
        wait_phase(0, 10);
        req = 3'b000;
        wait_phase(SETTLE + SLOT - 1, 30);
        done = 3'b100;
        @(negedge clk_10MHz);
        done = 3'b000;
        wait_idle(30);
        chk("dlast_grant", 32'(gq[0]), 32'h4);
        chk("dlast_len", 32'(clen[0]), 32'd16);
        chk("dlast_ovr", 32'(ovr_cnt), 32'd0);

        // done on non-granted bits is ignored
        clear_logs();
        req  = 3'b001;
        done = 3'b110;
        wait_phase(0, 10);
        req = 3'b000;
        wait_idle(60);
        done = 3'b000;
        chk("dother_grant", 32'(gq[0]), 32'h1);
        chk("dother_len", 32'(clen[0]), 32'd16);
        chk("dother_ovr", 32'(ovr_cnt), 32'd1);

        // Lock loss at active cycle 5
        clear_logs();
        req = 3'b111;
        wait_phase(SETTLE + 4, 30);
        chk("lock_ctrl_before", 32'(dac1_control), 32'h1);
        locked = 1'b0;
        @(negedge clk_10MHz);
        chk("lock_grant_after", 32'(grant), 32'h0);
        chk("lock_ctrl_after", 32'(dac1_control), 32'h0);
        chk("lock_busy_after", 32'(busy), 32'h0);
        repeat (10) @(negedge clk_10MHz);
        chk("lock_no_grant", 32'(gq.size()), 32'd1);
        chk("lock_ctrl_len", 32'(clen[0]), 32'd5);
        chk("lock_ovr", 32'(ovr_cnt), 32'd0);
        locked = 1'b1;
        wait_grants(2, 10);
        chk("lock_next_grant", 32'(gq[1]), 32'h4);
        req = 3'b000;
        wait_idle(60);

        // Synchronous reset in active
        clear_logs();
        req = 3'b111;
        wait_phase(SETTLE + 2, 30);
        reset = 1'b1;
        chk("srst_ctrl_before", 32'(adc_control), 32'h1);
        @(negedge clk_10MHz);
        chk("srst_grant_after", 32'(grant), 32'h0);
        chk("srst_ctrl_after", 32'(adc_control), 32'h0);
        chk("srst_busy_after", 32'(busy), 32'h0);
        @(negedge clk_10MHz);
        reset = 1'b0;
        wait_grants(2, 10);
        chk("srst_first_grant", 32'(gq[1]), 32'h1);
        req = 3'b000;
        wait_idle(60);

        // Configuration isolation on dac1
        clear_logs();
        mux_cfg_dac1 = 19'h00001;
        req = 3'b010;
        wait_phase(0, 10);
        mux_cfg_dac1 = 19'h7FFFF;
        req = 3'b000;
        wait_phase(SETTLE + 5, 20);
        chk("cfg_held", 32'(mux_signals), 32'h1);
        wait_phase(SETTLE + SLOT, 30);
        chk("cfg_guard_mux", 32'(mux_signals), 32'h0);
        chk("cfg_guard_grant", 32'(grant), 32'h0);
        wait_idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
